// File: rtl/resp_capture_misr.sv
`default_nettype none
// ============================================================================
// Module   : resp_capture_misr
// Purpose  : Captures (pattern, response) pairs into a truth table, compares
//            it with a golden table and compacts responses into a 16-bit MISR.
//            Optional MISR build enabled by macro RESP_CAPTURE_MISR_EN.
// Revision : 1.0  initial release
// ============================================================================
module resp_capture_misr #(
  parameter int N_IN  = 3,
  parameter int CNT_W = 4
) (
  input  logic                   CK,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   pat_valid,
  input  logic [N_IN-1:0]        pat,
  input  logic                   resp,
  input  logic [(1<<N_IN)-1:0]   expected_tt,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   truth_table,
  output logic                   mismatch,
  output logic [CNT_W-1:0]       mismatch_count,
  output logic                   dup_err,
  output logic [15:0]            signature
);

  localparam int c_n_pat = 1 << N_IN;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_n_pat-1:0]   r_seen;
  logic [c_n_pat-1:0]   r_exp;
  logic [c_n_pat-1:0]   r_tt;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_dup;
  logic                 r_mismatch;
  logic                 w_all_seen;
  logic                 w_accept;

  assign w_all_seen = &r_seen;
  // Samples arriving in the single cycle between "all seen" and DONE are dropped.
  assign w_accept   = (r_state == S_CAPTURE) && pat_valid && !start && !w_all_seen;

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        if (start)           w_state_nxt = S_CAPTURE;
        else if (w_all_seen) w_state_nxt = S_DONE;
      end
      S_DONE:    if (start) w_state_nxt = S_CAPTURE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      r_seen     <= '0;
      r_exp      <= '0;
      r_tt       <= '0;
      r_cnt      <= '0;
      r_dup      <= 1'b0;
      r_mismatch <= 1'b0;
    end else if (start) begin
      r_seen     <= '0;
      r_exp      <= expected_tt;
      r_tt       <= '0;
      r_cnt      <= '0;
      r_dup      <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tt[pat]   <= resp;
        r_seen[pat] <= 1'b1;
        if (r_seen[pat]) begin
          r_dup <= 1'b1;
        end else if ((resp != r_exp[pat]) && (r_cnt != {CNT_W{1'b1}})) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      // Registered on the same edge that enters DONE.
      if ((r_state == S_CAPTURE) && w_all_seen) begin
        r_mismatch <= |(r_tt ^ r_exp);
      end
    end
  end

`ifdef RESP_CAPTURE_MISR_EN
  logic [15:0] r_sig;

  always_ff @(posedge CK or negedge reset) begin
    if (!reset)        r_sig <= 16'h0000;
    else if (start)    r_sig <= 16'hFFFF;
    else if (w_accept) r_sig <= {r_sig[14:0], 1'b0} ^ ((r_sig[15] ^ resp) ? 16'h1021 : 16'h0000);
  end

  assign signature = r_sig;
`else
  assign signature = 16'h0000;
`endif

  assign busy           = (r_state == S_CAPTURE);
  assign done           = (r_state == S_DONE);
  assign truth_table    = r_tt;
  assign mismatch       = r_mismatch;
  assign mismatch_count = r_cnt;
  assign dup_err        = r_dup;

endmodule
`default_nettype wire

// File: tb/tb_resp_capture_misr.sv
`default_nettype none
// ============================================================================
// Module   : tb_resp_capture_misr
// Purpose  : Randomised scoreboard bench for resp_capture_misr.
// Revision : 1.0  initial release
// ============================================================================
module tb_resp_capture_misr;
  localparam int N_IN  = 3;
  localparam int CNT_W = 4;
  localparam int NP    = 1 << N_IN;
`ifdef RESP_CAPTURE_MISR_EN
  localparam bit c_misr = 1'b1;
`else
  localparam bit c_misr = 1'b0;
`endif
  localparam logic [15:0] c_seed = c_misr ? 16'hFFFF : 16'h0000;

  logic             CK = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             pat_valid = 1'b0;
  logic [N_IN-1:0]  pat = '0;
  logic             resp = 1'b0;
  logic [NP-1:0]    expected_tt = '0;
  logic             busy, done, mismatch, dup_err;
  logic [NP-1:0]    truth_table;
  logic [CNT_W-1:0] mismatch_count;
  logic [15:0]      signature;

  resp_capture_misr #(.N_IN(N_IN), .CNT_W(CNT_W)) dut (
    .CK(CK), .reset(reset), .start(start), .pat_valid(pat_valid), .pat(pat),
    .resp(resp), .expected_tt(expected_tt), .busy(busy), .done(done),
    .truth_table(truth_table), .mismatch(mismatch), .mismatch_count(mismatch_count),
    .dup_err(dup_err), .signature(signature)
  );

  always #5 CK = ~CK;

  typedef struct packed {
    logic [NP-1:0]    tt;
    logic             mm;
    logic [CNT_W-1:0] cnt;
    logic             dup;
    logic [15:0]      sig;
  } exp_t;

  exp_t sb_q[$];
  int   st_pat[$];
  bit   st_resp[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] misr_step(input logic [15:0] s, input bit r);
    int v;
    v = (int'(s) * 2) % 65536;
    if ((s[15] ^ r) == 1'b1) v = v ^ 'h1021;
    return v[15:0];
  endfunction

  // Expected run result from the sample list: last write wins, first visit counts.
  function automatic exp_t model(input logic [NP-1:0] e);
    exp_t        x;
    bit [NP-1:0] seen;
    int          cnt;
    int          p;
    logic [15:0] s;
    seen = '0; cnt = 0; s = 16'hFFFF;
    x = '0;
    foreach (st_pat[i]) begin
      p = st_pat[i];
      if (seen[p]) x.dup = 1'b1;
      else begin
        seen[p] = 1'b1;
        if (st_resp[i] != e[p]) cnt++;
      end
      x.tt[p] = st_resp[i];
      s = misr_step(s, st_resp[i]);
    end
    x.cnt = (cnt > (1 << CNT_W) - 1) ? {CNT_W{1'b1}} : CNT_W'(cnt);
    x.mm  = (x.tt != e);
    x.sig = c_misr ? s : 16'h0000;
    return x;
  endfunction

  // Monitor: compares each completed run against the head of the scoreboard.
  exp_t mon_x;
  logic mon_prev_done = 1'b0;
  always @(negedge CK) begin
    if (reset && done && !mon_prev_done) begin
      if (sb_q.size() == 0) begin
        checks++;
        $display("FAIL sb_unexpected_done: got done=1 expected no pending run");
      end else begin
        mon_x = sb_q.pop_front();
        check("sb_tt", truth_table, mon_x.tt);
        check("sb_mismatch", mismatch, mon_x.mm);
        check("sb_count", mismatch_count, mon_x.cnt);
        check("sb_dup", dup_err, mon_x.dup);
        check("sb_sig", signature, mon_x.sig);
        check("sb_busy", busy, 0);
      end
    end
    mon_prev_done = done;
  end

  task automatic do_run(input logic [NP-1:0] e, input bit gaps, input bit do_start);
    if (do_start) begin
      @(negedge CK); expected_tt = e; start = 1'b1;
      @(negedge CK); start = 1'b0;
      check("start_busy", busy, 1);
      check("start_sig", signature, c_seed);
      check("start_tt", truth_table, 0);
      check("start_done", done, 0);
    end
    sb_q.push_back(model(e));
    for (int i = 0; i < st_pat.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) @(negedge CK);
      pat_valid = 1'b1; pat = N_IN'(st_pat[i]); resp = st_resp[i];
      @(negedge CK); pat_valid = 1'b0;
      check("no_early_done", done, 0);
    end
    @(negedge CK);
    check("done_latency", done, 1);
  endtask

  task automatic load_parity(input int flip);
    st_pat.delete(); st_resp.delete();
    for (int k = 0; k < NP; k++) begin
      st_pat.push_back(k);
      st_resp.push_back(^k[N_IN-1:0] ^ (k == flip));
    end
  endtask

  task automatic load_random(input logic [NP-1:0] e);
    int perm[NP];
    int j, t, p;
    st_pat.delete(); st_resp.delete();
    for (int k = 0; k < NP; k++) perm[k] = k;
    for (int k = NP - 1; k > 0; k--) begin
      j = $urandom_range(0, k); t = perm[k]; perm[k] = perm[j]; perm[j] = t;
    end
    for (int k = 0; k < NP; k++) begin
      st_pat.push_back(perm[k]);
      st_resp.push_back(($urandom_range(0, 3) == 0) ? ~e[perm[k]] : e[perm[k]]);
      if (k > 0 && k < NP - 1 && $urandom_range(0, 4) == 0) begin
        p = perm[$urandom_range(0, k)];
        st_pat.push_back(p);
        st_resp.push_back(1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    exp_t x;
    logic [NP-1:0] e;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tt", truth_table, 0);
    check("rst_sig", signature, 0);
    check("rst_cnt", mismatch_count, 0);
    @(negedge CK); reset = 1'b1;

    // Samples in IDLE are ignored.
    pat_valid = 1'b1; pat = 3; resp = 1'b1;
    @(negedge CK); pat_valid = 1'b0;
    check("idle_ignore_tt", truth_table, 0);
    check("idle_ignore_busy", busy, 0);

    // Parity table in order, all matching.
    load_parity(-1);
    do_run(8'h96, 1'b0, 1'b1);
    check("parity_tt", truth_table, 8'h96);
    x = model(8'h96);
    pat_valid = 1'b1; pat = 5; resp = 1'b1;
    @(negedge CK); pat_valid = 1'b0;
    check("frozen_tt", truth_table, 8'h96);
    check("frozen_sig", signature, x.sig);
    check("frozen_done", done, 1);

    // Pattern 5 inverted.
    load_parity(5);
    do_run(8'h96, 1'b0, 1'b1);
    check("flip_tt", truth_table, 8'hB6);
    check("flip_mm", mismatch, 1);
    check("flip_cnt", mismatch_count, 1);

    // All-zero responses: known signature.
    st_pat.delete(); st_resp.delete();
    for (int k = 0; k < NP; k++) begin st_pat.push_back(k); st_resp.push_back(1'b0); end
    do_run(8'h00, 1'b0, 1'b1);
    check("zero_sig", signature, c_misr ? 16'hE1F0 : 16'h0000);
    check("zero_mm", mismatch, 0);

    // Duplicate pattern 3.
    load_parity(-1);
    st_pat.insert(4, 3); st_resp.insert(4, 1'b0);
    do_run(8'h96, 1'b0, 1'b1);
    check("dup_err", dup_err, 1);
    check("dup_cnt", mismatch_count, 0);

    // Asynchronous reset after four samples.
    @(negedge CK); expected_tt = 8'h96; start = 1'b1;
    @(negedge CK); start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pat_valid = 1'b1; pat = N_IN'(k); resp = 1'b1;
      @(negedge CK);
    end
    pat_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_tt", truth_table, 0);
    check("arst_sig", signature, 0);
    check("arst_cnt", mismatch_count, 0);
    @(negedge CK); reset = 1'b1;
    pat_valid = 1'b1; pat = 6; resp = 1'b1;
    @(negedge CK); pat_valid = 1'b0;
    check("post_rst_tt", truth_table, 0);
    check("post_rst_busy", busy, 0);

    // start collides with a sample mid-run.
    e = 8'h5A;
    @(negedge CK); expected_tt = e; start = 1'b1;
    @(negedge CK); start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pat_valid = 1'b1; pat = N_IN'(k); resp = ~e[k];
      @(negedge CK);
    end
    start = 1'b1; pat = 2; resp = 1'b1;
    @(negedge CK); start = 1'b0; pat_valid = 1'b0;
    check("coll_tt", truth_table, 0);
    check("coll_sig", signature, c_seed);
    check("coll_cnt", mismatch_count, 0);
    check("coll_busy", busy, 1);
    load_random(e);
    do_run(e, 1'b1, 1'b0);

    // Randomised runs.
    for (int r = 0; r < 20; r++) begin
      e = NP'($urandom);
      load_random(e);
      do_run(e, 1'b1, 1'b1);
    end

    repeat (2) @(negedge CK);
    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
`default_nettype wire
